// File: rtl/fir_pkg.sv
// Shared state encoding and result-narrowing helper for the complex decimating FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int WIDE = 128;

  // Narrow a sign-extended value to w bits: clamp when sat is set, otherwise the
  // caller keeps only the low w bits (two's-complement wrap).
  function automatic logic signed [WIDE-1:0] fit_width(
    input logic signed [WIDE-1:0] v,
    input int                     w,
    input logic                   sat
  );
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    hi = (WIDE'(1) <<< (w - 1)) - WIDE'(1);
    lo = -hi - WIDE'(1);
    if (!sat)        fit_width = v;
    else if (v > hi) fit_width = hi;
    else if (v < lo) fit_width = lo;
    else             fit_width = v;
  endfunction

endpackage

// File: rtl/fir_cplx_mac.sv
// Single complex multiply-accumulate lane: acc += x * c with full-precision products.
module fir_cplx_mac #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int ACC_WIDTH   = 70
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          enable,
  input  logic signed [DATA_WIDTH-1:0]  xr,
  input  logic signed [DATA_WIDTH-1:0]  xi,
  input  logic signed [COEFF_WIDTH-1:0] cr,
  input  logic signed [COEFF_WIDTH-1:0] ci,
  output logic signed [ACC_WIDTH-1:0]   acc_r,
  output logic signed [ACC_WIDTH-1:0]   acc_i
);

  logic signed [ACC_WIDTH-1:0] xr_w, xi_w, cr_w, ci_w;

  assign xr_w = ACC_WIDTH'(xr);
  assign xi_w = ACC_WIDTH'(xi);
  assign cr_w = ACC_WIDTH'(cr);
  assign ci_w = ACC_WIDTH'(ci);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= '0;
      acc_i <= '0;
    end else if (clear) begin
      acc_r <= '0;
      acc_i <= '0;
    end else if (enable) begin
      acc_r <= acc_r + xr_w * cr_w - xi_w * ci_w;
      acc_i <= acc_i + xr_w * ci_w + xi_w * cr_w;
    end
  end

endmodule

// File: rtl/fir_cplx_decim.sv
// Complex FIR with integrated decimation and overlapped input prefetch.
// Define FIR_CPLX_SATURATE_EN to saturate outputs instead of wrapping them.
//
// state | meaning
// FILL  | shift DECIMATION samples into the delay line, pending buffer first
// MAC   | one complex tap per cycle, prefetching new samples into pending
// WRITE | push the result once both output FIFOs have room, still prefetching
module fir_cplx_decim
  import fir_pkg::*;
#(
  parameter int TAP_NUMBER  = 20,
  parameter int DECIMATION  = 1,
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int FRAC_BITS   = 10,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(TAP_NUMBER) + 1,
  parameter logic [TAP_NUMBER-1:0][COEFF_WIDTH-1:0] REAL_COEFF = '0,
  parameter logic [TAP_NUMBER-1:0][COEFF_WIDTH-1:0] IMAG_COEFF = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic                  i_empty,
  output logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic                  q_empty,
  output logic                  q_rd_en,
  output logic [DATA_WIDTH-1:0] real_out,
  output logic                  real_wr_en,
  input  logic                  real_full,
  output logic [DATA_WIDTH-1:0] imag_out,
  output logic                  imag_wr_en,
  input  logic                  imag_full
);

  localparam int TW = $clog2(TAP_NUMBER);
  localparam int PW = $clog2(DECIMATION + 1);
`ifdef FIR_CPLX_SATURATE_EN
  localparam logic SATURATE = 1'b1;
`else
  localparam logic SATURATE = 1'b0;
`endif

  state_t        state, state_nx;
  logic [PW-1:0] fcnt, fcnt_nx;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tap, tap_nx;

  logic [DATA_WIDTH-1:0] dl_i [TAP_NUMBER];
  logic [DATA_WIDTH-1:0] dl_q [TAP_NUMBER];
  logic [DATA_WIDTH-1:0] pb_i [DECIMATION];
  logic [DATA_WIDTH-1:0] pb_q [DECIMATION];

  logic in_avail, out_ok;
  logic rd, pop, wr, mac_clear;
  logic shift_in, push;

  logic signed [ACC_WIDTH-1:0]  acc_r, acc_i, sh_r, sh_i;
  logic signed [DATA_WIDTH-1:0] res_r, res_i;

  assign in_avail = !i_empty && !q_empty;
  assign out_ok   = !real_full && !imag_full;

  always_comb begin
    state_nx  = state;
    fcnt_nx   = fcnt;
    tap_nx    = tap;
    rd        = 1'b0;
    pop       = 1'b0;
    wr        = 1'b0;
    mac_clear = 1'b0;
    case (state)
      FILL: begin
        // Pending samples are older than anything still in the FIFOs.
        if (pcnt != '0)    pop = 1'b1;
        else if (in_avail) rd  = 1'b1;
        if (pop || rd) begin
          fcnt_nx = fcnt + 1'b1;
          if (fcnt_nx == PW'(DECIMATION)) begin
            mac_clear = 1'b1;
            tap_nx    = '0;
            state_nx  = MAC;
          end
        end
      end
      MAC: begin
        rd = in_avail && (pcnt < PW'(DECIMATION));
        if (tap == TW'(TAP_NUMBER - 1)) state_nx = WRITE;
        else                            tap_nx   = tap + 1'b1;
      end
      WRITE: begin
        rd = in_avail && (pcnt < PW'(DECIMATION));
        if (out_ok) begin
          wr       = 1'b1;
          fcnt_nx  = '0;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  assign shift_in = pop || (rd && state == FILL);
  assign push     = rd && state != FILL;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
      fcnt  <= '0;
      tap   <= '0;
      pcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      tap   <= tap_nx;
      if (push)     pcnt <= pcnt + 1'b1;
      else if (pop) pcnt <= pcnt - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAP_NUMBER; k++) begin
        dl_i[k] <= '0;
        dl_q[k] <= '0;
      end
    end else if (shift_in) begin
      for (int k = TAP_NUMBER - 1; k > 0; k--) begin
        dl_i[k] <= dl_i[k-1];
        dl_q[k] <= dl_q[k-1];
      end
      dl_i[0] <= pop ? pb_i[0] : i_in;
      dl_q[0] <= pop ? pb_q[0] : q_in;
    end
  end

  // Pending buffer pops from slot 0 and appends at slot pcnt; never both in one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DECIMATION; k++) begin
        pb_i[k] <= '0;
        pb_q[k] <= '0;
      end
    end else if (push) begin
      for (int k = 0; k < DECIMATION; k++) begin
        if (PW'(k) == pcnt) begin
          pb_i[k] <= i_in;
          pb_q[k] <= q_in;
        end
      end
    end else if (pop) begin
      for (int k = 0; k < DECIMATION - 1; k++) begin
        pb_i[k] <= pb_i[k+1];
        pb_q[k] <= pb_q[k+1];
      end
    end
  end

  fir_cplx_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (mac_clear),
    .enable (state == MAC),
    .xr     ($signed(dl_i[tap])),
    .xi     ($signed(dl_q[tap])),
    .cr     ($signed(REAL_COEFF[tap])),
    .ci     ($signed(IMAG_COEFF[tap])),
    .acc_r  (acc_r),
    .acc_i  (acc_i)
  );

  assign sh_r  = acc_r >>> FRAC_BITS;
  assign sh_i  = acc_i >>> FRAC_BITS;
  assign res_r = DATA_WIDTH'(fit_width(WIDE'(sh_r), DATA_WIDTH, SATURATE));
  assign res_i = DATA_WIDTH'(fit_width(WIDE'(sh_i), DATA_WIDTH, SATURATE));

  // Read enables are held low while reset is asserted so no sample is lost.
  assign i_rd_en    = reset_n && rd;
  assign q_rd_en    = reset_n && rd;
  assign real_wr_en = wr;
  assign imag_wr_en = wr;
  assign real_out   = wr ? res_r : '0;
  assign imag_out   = wr ? res_i : '0;

endmodule

// File: tb/tb_fir_cplx_decim.sv
// Self-checking bench for fir_cplx_decim: four configurations, table vectors plus scoreboard.
module tb_fir_cplx_decim;

  localparam int NI   = 4;
  localparam int TAPS = 4;
  localparam logic [127:0] C_CASE1 = {32'd128, 32'd256, 32'd512, 32'd1024};
  localparam logic [127:0] C_J     = {96'd0, 32'd1024};
  localparam logic [127:0] C_FLAT  = {4{32'd4096}};
  localparam logic [127:0] C_ZERO  = '0;

`ifdef FIR_CPLX_SATURATE_EN
  localparam int E4_1 = 32767, E4_2 = 32767, E4_3 = 32767, E4_4 = 32767;
`else
  localparam int E4_1 = -4, E4_2 = -8, E4_3 = -12, E4_4 = -16;
`endif

  logic clock, reset_n;
  logic signed [31:0] i_in [NI];
  logic signed [31:0] q_in [NI];
  logic i_empty [NI], q_empty [NI], real_full [NI], imag_full [NI];
  logic i_rd_en [NI], q_rd_en [NI], real_wr_en [NI], imag_wr_en [NI];
  logic signed [31:0] real_out_v [NI];
  logic signed [31:0] imag_out_v [NI];
  logic [15:0] r16, i16;

  fir_cplx_decim #(.TAP_NUMBER(TAPS), .DECIMATION(1), .REAL_COEFF(C_CASE1), .IMAG_COEFF(C_ZERO)) u0 (
    .clock(clock), .reset_n(reset_n),
    .i_in(i_in[0]), .i_empty(i_empty[0]), .i_rd_en(i_rd_en[0]),
    .q_in(q_in[0]), .q_empty(q_empty[0]), .q_rd_en(q_rd_en[0]),
    .real_out(real_out_v[0]), .real_wr_en(real_wr_en[0]), .real_full(real_full[0]),
    .imag_out(imag_out_v[0]), .imag_wr_en(imag_wr_en[0]), .imag_full(imag_full[0]));

  fir_cplx_decim #(.TAP_NUMBER(TAPS), .DECIMATION(1), .REAL_COEFF(C_ZERO), .IMAG_COEFF(C_J)) u1 (
    .clock(clock), .reset_n(reset_n),
    .i_in(i_in[1]), .i_empty(i_empty[1]), .i_rd_en(i_rd_en[1]),
    .q_in(q_in[1]), .q_empty(q_empty[1]), .q_rd_en(q_rd_en[1]),
    .real_out(real_out_v[1]), .real_wr_en(real_wr_en[1]), .real_full(real_full[1]),
    .imag_out(imag_out_v[1]), .imag_wr_en(imag_wr_en[1]), .imag_full(imag_full[1]));

  fir_cplx_decim #(.TAP_NUMBER(TAPS), .DECIMATION(2), .REAL_COEFF(C_CASE1), .IMAG_COEFF(C_ZERO)) u2 (
    .clock(clock), .reset_n(reset_n),
    .i_in(i_in[2]), .i_empty(i_empty[2]), .i_rd_en(i_rd_en[2]),
    .q_in(q_in[2]), .q_empty(q_empty[2]), .q_rd_en(q_rd_en[2]),
    .real_out(real_out_v[2]), .real_wr_en(real_wr_en[2]), .real_full(real_full[2]),
    .imag_out(imag_out_v[2]), .imag_wr_en(imag_wr_en[2]), .imag_full(imag_full[2]));

  fir_cplx_decim #(.TAP_NUMBER(TAPS), .DECIMATION(1), .DATA_WIDTH(16),
                   .REAL_COEFF(C_FLAT), .IMAG_COEFF(C_ZERO)) u3 (
    .clock(clock), .reset_n(reset_n),
    .i_in(i_in[3][15:0]), .i_empty(i_empty[3]), .i_rd_en(i_rd_en[3]),
    .q_in(q_in[3][15:0]), .q_empty(q_empty[3]), .q_rd_en(q_rd_en[3]),
    .real_out(r16), .real_wr_en(real_wr_en[3]), .real_full(real_full[3]),
    .imag_out(i16), .imag_wr_en(imag_wr_en[3]), .imag_full(imag_full[3]));

  assign real_out_v[3] = 32'(signed'(r16));
  assign imag_out_v[3] = 32'(signed'(i16));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0, failed = 0, reads = 0, writes = 0, sel = 0, mcnt = 0;
  bit hold_full = 0, force_ie = 0, force_qe = 0, model_on = 0;
  logic signed [31:0] src_i [$], src_q [$], sb_r [$], sb_i [$];
  logic signed [31:0] mdl_i [TAPS], mdl_q [TAPS];

  typedef struct {
    int inst; int xi; int xq; bit has_exp; int er; int ei;
  } vec_t;
  vec_t vt [19];

  function automatic int dec_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int dw_of(input int k);
    return (k == 3) ? 16 : 32;
  endfunction

  function automatic int coef(input int k, input int t, input bit im);
    case (k)
      1:       return (im && t == 0) ? 1024 : 0;
      3:       return im ? 0 : 4096;
      default: return im ? 0 : (1024 >> t);
    endcase
  endfunction

  function automatic logic signed [31:0] narrow(input logic signed [127:0] acc, input int dw);
    logic signed [127:0] s;
    s = acc >>> 10;
`ifdef FIR_CPLX_SATURATE_EN
    begin
      logic signed [127:0] hi, lo;
      hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
    end
`endif
    if (dw == 16) return 32'(signed'(s[15:0]));
    return s[31:0];
  endfunction

  function automatic int rnd20();
    return int'($urandom_range(2097152, 0)) - 1048576;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < TAPS; t++) begin mdl_i[t] = '0; mdl_q[t] = '0; end
    mcnt = 0;
  endtask

  task automatic model_push(input logic signed [31:0] xi, input logic signed [31:0] xq);
    logic signed [127:0] ar, ai;
    for (int t = TAPS - 1; t > 0; t--) begin mdl_i[t] = mdl_i[t-1]; mdl_q[t] = mdl_q[t-1]; end
    mdl_i[0] = xi;
    mdl_q[0] = xq;
    mcnt++;
    if (mcnt % dec_of(sel) == 0) begin
      ar = '0;
      ai = '0;
      for (int t = 0; t < TAPS; t++) begin
        ar += 128'(mdl_i[t]) * 128'(coef(sel, t, 0)) - 128'(mdl_q[t]) * 128'(coef(sel, t, 1));
        ai += 128'(mdl_i[t]) * 128'(coef(sel, t, 1)) + 128'(mdl_q[t]) * 128'(coef(sel, t, 0));
      end
      sb_r.push_back(narrow(ar, dw_of(sel)));
      sb_i.push_back(narrow(ai, dw_of(sel)));
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NI; k++) begin
      bit act;
      act = (k == sel) && (src_i.size() != 0);
      i_in[k]      = act ? src_i[0] : '0;
      q_in[k]      = act ? src_q[0] : '0;
      i_empty[k]   = !act || force_ie;
      q_empty[k]   = !act || force_qe;
      real_full[k] = (k == sel) && hold_full;
      imag_full[k] = 1'b0;
    end
  endtask

  // Sample at negedge, pop the source model just after the following posedge.
  task automatic step();
    bit rd, wr;
    logic signed [31:0] ro, io, er, ei, xi, xq;
    @(negedge clock);
    rd = i_rd_en[sel];
    wr = real_wr_en[sel];
    ro = real_out_v[sel];
    io = imag_out_v[sel];
    tests++;
    if (i_rd_en[sel] !== q_rd_en[sel] || real_wr_en[sel] !== imag_wr_en[sel] ||
        (!wr && (ro !== 0 || io !== 0))) begin
      failed++;
      $display("FAIL handshake inst=%0d: rd %b/%b wr %b/%b out %0d/%0d, required equal enables and zero outputs when idle",
               sel, i_rd_en[sel], q_rd_en[sel], real_wr_en[sel], imag_wr_en[sel], ro, io);
    end
    if (!reset_n) begin
      tests++;
      if (rd !== 1'b0 || wr !== 1'b0 || ro !== 0 || io !== 0) begin
        failed++;
        $display("FAIL reset_outputs inst=%0d: rd=%b wr=%b re=%0d im=%0d, required all 0", sel, rd, wr, ro, io);
      end
    end
    if (wr) begin
      writes++;
      tests++;
      if (sb_r.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write inst=%0d: got %0d/%0d, required no write", sel, ro, io);
      end else begin
        er = sb_r.pop_front();
        ei = sb_i.pop_front();
        if (ro !== er || io !== ei) begin
          failed++;
          $display("FAIL output inst=%0d: got %0d/%0d, required %0d/%0d", sel, ro, io, er, ei);
        end
      end
    end
    @(posedge clock);
    #1;
    if (rd && src_i.size() != 0) begin
      reads++;
      xi = src_i.pop_front();
      xq = src_q.pop_front();
      if (model_on) model_push(xi, xq);
    end
    drive();
  endtask

  task automatic run_until_done(input int maxc);
    int n;
    n = 0;
    while ((sb_r.size() != 0 || src_i.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    tests++;
    if (sb_r.size() != 0 || src_i.size() != 0) begin
      failed++;
      $display("FAIL timeout inst=%0d: %0d outputs and %0d inputs left, required 0/0", sel, sb_r.size(), src_i.size());
    end
  endtask

  task automatic run_random(input int inst, input int n);
    sel = inst;
    model_clear();
    model_on = 1;
    for (int k = 0; k < n; k++) begin
      src_i.push_back(rnd20());
      src_q.push_back(rnd20());
    end
    drive();
    run_until_done(600);
    repeat (TAPS + 4) step();
    model_on = 0;
  endtask

  initial begin
    int n;
    vt[0]  = '{0, 1024, 0, 1, 1024, 0};
    vt[1]  = '{0, 0, 0, 1, 512, 0};
    vt[2]  = '{0, 0, 0, 1, 256, 0};
    vt[3]  = '{0, 0, 0, 1, 128, 0};
    vt[4]  = '{0, 0, 0, 1, 0, 0};
    vt[5]  = '{1, 1024, 0, 1, 0, 1024};
    vt[6]  = '{1, 0, 1024, 1, -1024, 0};
    vt[7]  = '{2, 1024, 0, 0, 0, 0};
    vt[8]  = '{2, 0, 0, 1, 512, 0};
    vt[9]  = '{2, 0, 0, 0, 0, 0};
    vt[10] = '{2, 0, 0, 1, 128, 0};
    vt[11] = '{2, 0, 0, 0, 0, 0};
    vt[12] = '{2, 0, 0, 1, 0, 0};
    vt[13] = '{3, 32767, 0, 1, E4_1, 0};
    vt[14] = '{3, 32767, 0, 1, E4_2, 0};
    vt[15] = '{3, 32767, 0, 1, E4_3, 0};
    vt[16] = '{3, 32767, 0, 1, E4_4, 0};
    vt[17] = '{3, 32767, 0, 1, E4_4, 0};
    vt[18] = '{3, 32767, 0, 1, E4_4, 0};

    reset_n = 1'b0;
    model_clear();
    drive();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();

    // Table-driven impulse, j-rotation, decimation and narrowing cases.
    for (int r = 0; r < 19; r++) begin
      if (vt[r].inst != sel) begin
        run_until_done(400);
        sel = vt[r].inst;
      end
      src_i.push_back(vt[r].xi);
      src_q.push_back(vt[r].xq);
      if (vt[r].has_exp) begin
        sb_r.push_back(vt[r].er);
        sb_i.push_back(vt[r].ei);
      end
      drive();
    end
    run_until_done(400);
    repeat (TAPS + 4) step();

    // Backpressure on the D=2 instance: two fill reads plus two prefetches only.
    sel = 2;
    model_clear();
    model_on = 1;
    hold_full = 1;
    for (int k = 0; k < 8; k++) begin
      src_i.push_back(rnd20());
      src_q.push_back(rnd20());
    end
    drive();
    reads = 0;
    writes = 0;
    repeat (50) step();
    tests++;
    if (reads != 4) begin
      failed++;
      $display("FAIL backpressure_reads: got %0d, required 4", reads);
    end
    tests++;
    if (writes != 0) begin
      failed++;
      $display("FAIL backpressure_writes: got %0d, required 0", writes);
    end
    hold_full = 0;
    drive();
    run_until_done(400);
    repeat (TAPS + 4) step();
    model_on = 0;

    // Only one FIFO non-empty: no reads in either direction.
    sel = 0;
    force_qe = 1;
    src_i.push_back(1000);
    src_q.push_back(500);
    src_i.push_back(77);
    src_q.push_back(-3);
    drive();
    reads = 0;
    repeat (20) step();
    force_qe = 0;
    force_ie = 1;
    drive();
    repeat (10) step();
    tests++;
    if (reads != 0) begin
      failed++;
      $display("FAIL single_fifo_read: got %0d reads, required 0", reads);
    end
    force_ie = 0;
    drive();

    // Reset in the middle of MAC discards the sum, pending data and delay line.
    n = 0;
    while (reads == 0 && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (reads == 0) begin
      failed++;
      $display("FAIL first_read: got 0 reads, required at least 1");
    end
    step();
    src_i.push_back(5);
    src_q.push_back(6);
    drive();
    reset_n = 1'b0;
    model_clear();
    model_on = 1;
    repeat (3) step();
    reset_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      src_i.push_back(rnd20());
      src_q.push_back(rnd20());
    end
    drive();
    run_until_done(600);
    repeat (TAPS + 4) step();
    model_on = 0;

    run_random(1, 10);
    run_random(2, 10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
